// File: rtl/snespad_pkg.sv
// snespad_pkg: shared frame FSM state type, parameter limits and default
// timing constants for the multi-pad SNES/NES controller reader.
package snespad_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SCLOW,
        SCHIGH,
        DONE
    } state_e;

    // Legal parameter ranges
    localparam int unsigned NPADS_MIN = 1;
    localparam int unsigned NPADS_MAX = 4;
    localparam int unsigned NBITS_MIN = 8;
    localparam int unsigned NBITS_MAX = 32;

    // Default timing (ns)
    localparam int unsigned DEF_CLK_PER_NS = 40;
    localparam int unsigned DEF_HALF_NS    = 6000;
    localparam int unsigned DEF_POLL_NS    = 16_000_000;

    // Prescaler terminal counts must never be zero
    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

endpackage

// File: rtl/snespad_tick.sv
// snespad_tick: free-running prescaler producing a one-cycle pulse every
// TERM cycles while en_i is high; counter is held at zero when disabled.
module snespad_tick #(
    parameter int unsigned TERM = 1
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CW = (TERM > 1) ? $clog2(TERM) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    // Terminal-count detect and next count value
    always_comb begin
        last   = (cnt_q == CW'(TERM - 1));
        tick_o = en_i && last;
        if (!en_i || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snespad_multi.sv
// snespad_multi: reads NPADS SNES/NES controllers sharing one clock/latch
// pair. Frames start on start_i or the auto-poll prescaler and deliver all
// pads' buttons (1 = pressed) with a one-cycle valid_o pulse.
// Optional feature macro: SNESPAD_EDGE_EN adds pressed_o / released_o.
module snespad_multi
    import snespad_pkg::*;
#(
    parameter int unsigned CLK_PER_NS = DEF_CLK_PER_NS,
    parameter int unsigned NPADS      = 2,
    parameter int unsigned NBITS      = 16,
    parameter int unsigned HALF_NS    = DEF_HALF_NS,
    parameter int unsigned POLL_NS    = DEF_POLL_NS
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   en_i,
    input  logic                   start_i,
    output logic                   dclock_o,
    output logic                   dlatch_o,
    input  logic [NPADS-1:0]       sdata_i,
    output logic [NPADS*NBITS-1:0] vdata_o,
    output logic                   valid_o,
`ifdef SNESPAD_EDGE_EN
    output logic [NPADS*NBITS-1:0] pressed_o,
    output logic [NPADS*NBITS-1:0] released_o,
`endif
    output logic                   busy_o
);

    localparam int unsigned TICK_TERM = at_least_one(HALF_NS / CLK_PER_NS);
    localparam int unsigned POLL_TERM = at_least_one(POLL_NS / CLK_PER_NS);
    localparam int unsigned BW        = $clog2(NBITS + 1);
    localparam int unsigned VW        = NPADS * NBITS;

    if (NPADS < NPADS_MIN || NPADS > NPADS_MAX) begin : g_bad_npads
        $error("snespad_multi: NPADS out of range");
    end
    if (NBITS < NBITS_MIN || NBITS > NBITS_MAX) begin : g_bad_nbits
        $error("snespad_multi: NBITS out of range");
    end

    logic tick;
    logic poll;

    snespad_tick #(.TERM(TICK_TERM)) u_tick (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (1'b1),
        .tick_o (tick)
    );

    snespad_tick #(.TERM(POLL_TERM)) u_poll (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (en_i),
        .tick_o (poll)
    );

    // ------------------------------------------------------------------
    // Input synchroniser (idle-high so an unplugged pad reads released)
    // ------------------------------------------------------------------
    logic [NPADS-1:0] meta_q, sync_q;

    // Two-flop synchroniser per pad data line
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= sdata_i;
            sync_q <= meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          lcnt_q, lcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          shift_en;

    // State, pending-request and counter registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            lcnt_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            lcnt_q  <= lcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next-state logic; bcnt_q counts bits already sampled. After the last
    // bit is taken one more SCLOW/SCHIGH pair runs so the pad sees NBITS
    // clock pulses, matching the console's framing.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        lcnt_d   = lcnt_q;
        bcnt_d   = bcnt_q;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i || poll) begin
                    req_d = 1'b1;
                end
                if (tick && (req_q || start_i || poll)) begin
                    state_d = LATCH;
                    req_d   = 1'b0;
                    lcnt_d  = 1'b0;
                    bcnt_d  = '0;
                end
            end
            LATCH: begin
                if (tick) begin
                    if (lcnt_q) begin
                        shift_en = 1'b1;
                        bcnt_d   = BW'(1);
                        state_d  = SCLOW;
                    end else begin
                        lcnt_d = 1'b1;
                    end
                end
            end
            SCLOW: begin
                if (tick) begin
                    state_d = SCHIGH;
                end
            end
            SCHIGH: begin
                if (tick) begin
                    if (bcnt_q == BW'(NBITS)) begin
                        state_d = DONE;
                    end else begin
                        shift_en = 1'b1;
                        bcnt_d   = bcnt_q + 1'b1;
                        state_d  = SCLOW;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs and datapath
    // ------------------------------------------------------------------
    logic          dclock_q, dclock_d;
    logic          dlatch_q, dlatch_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [VW-1:0] vdata_q, vdata_d;
    logic [VW-1:0] sr_q, sr_d;

    // Output decode from the upcoming state so pad lines come straight off flops
    always_comb begin
        dclock_d = (state_d != SCLOW);
        dlatch_d = (state_d == LATCH);
        busy_d   = (state_d != IDLE);
        valid_d  = (state_q == DONE);
        vdata_d  = valid_d ? sr_q : vdata_q;
    end

    // Per-pad shift-left, first bit ends in the MSB, stored as pressed=1
    always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
            for (int unsigned p = 0; p < NPADS; p++) begin
                sr_d[p*NBITS +: NBITS] = {sr_q[p*NBITS +: NBITS-1], ~sync_q[p]};
            end
        end
    end

    // Output and shift-register flops
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dclock_q <= 1'b1;
            dlatch_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            vdata_q  <= '0;
            sr_q     <= '0;
        end else begin
            dclock_q <= dclock_d;
            dlatch_q <= dlatch_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            vdata_q  <= vdata_d;
            sr_q     <= sr_d;
        end
    end

    assign dclock_o = dclock_q;
    assign dlatch_o = dlatch_q;
    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign vdata_o  = vdata_q;

`ifdef SNESPAD_EDGE_EN
    logic [VW-1:0] pressed_q, pressed_d;
    logic [VW-1:0] released_q, released_d;

    // Edge detect against the previously delivered frame (vdata_q)
    always_comb begin
        pressed_d  = '0;
        released_d = '0;
        if (valid_d) begin
            pressed_d  = sr_q & ~vdata_q;
            released_d = ~sr_q & vdata_q;
        end
    end

    // Edge flags pulse together with valid_o
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pressed_q  <= '0;
            released_q <= '0;
        end else begin
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign pressed_o  = pressed_q;
    assign released_o = released_q;
`endif

endmodule
